shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
- Shares one combinational barrel shifter between two requesters: port 0 (ALU-side) and port 1 (iterative multiply/divide sequencer).
- Round-robin arbitration, one grant per cycle; each port has its own one-entry response buffer with a valid/ready handshake.
- Sits between the execute-stage requesters and the team's `shifter` datapath module.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- PRIO_RESET, 0, port that wins the first tie after reset (0 or 1).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid[1:0]  in  2  per-port request valid.
- req_ready[1:0]  out  2  per-port request accept (combinational grant).
- req_a0, req_a1  in  32 each  operand A per port.
- req_b0, req_b1  in  5 each  shift amount per port.
- req_op0, req_op1  in  2 each  Shiftop per port.
- rsp_valid[1:0]  out  2  per-port response valid.
- rsp_ready[1:0]  in  2  per-port response accept.
- rsp_data0, rsp_data1  out  32 each  per-port result.

Behaviour:
- Reset: all outputs 0 (rsp_valid=0, rsp_data=0, req_ready=0); last_grant=~PRIO_RESET.
- Op encoding: 00 SLL; 11 SRL; 10 SRA (sign-fill from A[31]); 01 gives result 0. B is used as 0..31, never masked further.
- Per-port buffer states:
  - EMPTY→FULL on grant.
  - FULL→EMPTY on rsp_valid&rsp_ready with no same-cycle grant.
  - FULL→FULL on drain plus same-cycle grant (buffer overwritten with new result).
- Eligibility: elig_i = req_valid[i] & (buffer EMPTY | rsp_ready[i]).
- Arbitration:
  - Exactly one elig → grant it.
  - Both elig → grant the port != last_grant.
  - last_grant updates only on a grant.
  - req_ready[i] = grant_i. It is combinational on req_valid, rsp_ready and state; no combinational path from req_a/b/op.
- Datapath: the granted request's A/B/op are muxed into the shifter. The result is registered into that port's rsp_data at the granting edge.
- Latency: handshake at edge T → rsp_valid=1 with data right after T (1 cycle). Full throughput per port when rsp_ready is held high.
- rsp_data stays stable while rsp_valid=1 and not accepted. After a drain without a refill, rsp_data holds its last value.
- Requests are never dropped. Requester payload must remain stable while req_valid=1 and req_ready=0.
- Async reset mid-operation: buffers clear immediately and any pending responses are discarded. Arbitration restarts from the reset state.
- Neither port can starve: under continuous contention, grants alternate 0,1,0,1…

Optional Feature:
- SHIFT_ARB_PERF_EN defined:
  - Adds output ports perf_grant0, perf_grant1 (32-bit, count grants per port) and perf_conflict (32-bit, counts cycles with both elig).
  - All counters wrap, reset to 0 and are read-only.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package: Shiftop encodings SHOP_SLL=2'b00, SHOP_SRA=2'b10, SHOP_SRL=2'b11; buffer state constants EMPTY/FULL; port index constants.
- Sub-module: instantiate the existing `shifter` (A, B, Shiftop, Result) as the single shared datapath. Arbiter logic stays inline.

Test Plan:
- Port 0 only: SLL, A=0x0000_0001, B=4, rsp_ready0=1 → req_ready0=1 same cycle; next cycle rsp_valid0=1, rsp_data0=0x0000_0010.
- Both request at once (PRIO_RESET=0): p0 SRA A=0x8000_0000 B=31; p1 SRL A=0x8000_0000 B=31 → cycle 1: grant p0, result 0xFFFF_FFFF; cycle 2: grant p1, result 0x0000_0001; p1's req_ready stays 0 until its grant.
- Backpressure: rsp_ready0=0 with a second p0 request pending → req_ready0=0 and rsp_data0 stable for 5 cycles. Meanwhile p1 SRL A=0xF0 B=4 is granted and returns 0x0F. Raising rsp_ready0 drains and refills p0 in the same cycle.
- Op 01, A=0xFFFF_FFFF, B=3 → rsp_data=0x0000_0000. SRA A=0x7FFF_FFFF B=31 → 0x0000_0000.
- Sustained contention for 8 cycles, rsp_ready=2'b11 → grant sequence alternates 0,1,0,1,0,1,0,1. With SHIFT_ARB_PERF_EN: perf_grant0=4, perf_grant1=4, perf_conflict=8.
- resetn low asynchronously while rsp_valid=2'b11 → rsp_valid=0 before the next clk edge. After release, a tie grants PRIO_RESET first.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for shift_arbiter: shift-op encodings, response-buffer
// state and port indices.
package shift_arbiter_pkg;

    localparam logic [1:0] SHOP_SLL  = 2'b00;
    localparam logic [1:0] SHOP_ZERO = 2'b01;
    localparam logic [1:0] SHOP_SRA  = 2'b10;
    localparam logic [1:0] SHOP_SRL  = 2'b11;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    localparam int PORT_ALU    = 0;
    localparam int PORT_MULDIV = 1;
    localparam int NUM_PORTS   = 2;

endpackage

// File: rtl/shifter.sv
// Combinational 32-bit barrel shifter: SLL, SRL, SRA (sign fill), op 01 yields 0.
module shifter
    import shift_arbiter_pkg::*;
(
    input  logic [31:0] A,
    input  logic [4:0]  B,
    input  logic [1:0]  Shiftop,
    output logic [31:0] Result
);

    always_comb begin
        Result = '0;
        case (Shiftop)
            SHOP_SLL: Result = A << B;
            SHOP_SRL: Result = A >> B;
            SHOP_SRA: Result = $unsigned($signed(A) >>> B);
            default:  Result = '0;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one barrel shifter between two requesters, each with a
// one-entry response buffer. Define SHIFT_ARB_PERF_EN to add grant/conflict counters.
//
// Handshake: a request transfers on a rising edge where req_valid[i] & req_ready[i];
// a response transfers where rsp_valid[i] & rsp_ready[i]. Neither valid may depend
// on its ready, and a pending request's payload must stay stable until accepted.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit PRIO_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [DATA_WIDTH-1:0] req_a0,
    input  logic [DATA_WIDTH-1:0] req_a1,
    input  logic [4:0]            req_b0,
    input  logic [4:0]            req_b1,
    input  logic [1:0]            req_op0,
    input  logic [1:0]            req_op1,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data0,
    output logic [DATA_WIDTH-1:0] rsp_data1
`ifdef SHIFT_ARB_PERF_EN
    ,
    output logic [31:0]           perf_grant0,
    output logic [31:0]           perf_grant1,
    output logic [31:0]           perf_conflict
`endif
);

    buf_state_e            buf_q [NUM_PORTS];
    buf_state_e            buf_d [NUM_PORTS];
    logic                  last_grant_q;
    logic [1:0]            elig;
    logic [1:0]            grant;
    logic [DATA_WIDTH-1:0] data_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0] sh_a;
    logic [4:0]            sh_b;
    logic [1:0]            sh_op;
    logic [DATA_WIDTH-1:0] sh_result;

    // A full buffer is still eligible when it drains in the same cycle.
    always_comb begin
        elig  = '0;
        grant = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = req_valid[i] & ((buf_q[i] == BUF_EMPTY) | rsp_ready[i]);
        end
        if (resetn) begin
            if (&elig) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = elig;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            buf_d[i] = buf_q[i];
            if (grant[i]) begin
                buf_d[i] = BUF_FULL;
            end else if ((buf_q[i] == BUF_FULL) && rsp_ready[i]) begin
                buf_d[i] = BUF_EMPTY;
            end
        end
    end

    always_comb begin
        sh_a  = grant[PORT_MULDIV] ? req_a1  : req_a0;
        sh_b  = grant[PORT_MULDIV] ? req_b1  : req_b0;
        sh_op = grant[PORT_MULDIV] ? req_op1 : req_op0;
    end

    shifter u_shifter (
        .A       (sh_a),
        .B       (sh_b),
        .Shiftop (sh_op),
        .Result  (sh_result)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                buf_q[i]  <= BUF_EMPTY;
                data_q[i] <= '0;
            end
            last_grant_q <= ~PRIO_RESET;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                buf_q[i] <= buf_d[i];
                if (grant[i]) begin
                    data_q[i] <= sh_result;
                end
            end
            if (|grant) begin
                last_grant_q <= grant[PORT_MULDIV];
            end
        end
    end

    assign req_ready = grant;
    assign rsp_valid = {buf_q[PORT_MULDIV] == BUF_FULL, buf_q[PORT_ALU] == BUF_FULL};
    assign rsp_data0 = data_q[PORT_ALU];
    assign rsp_data1 = data_q[PORT_MULDIV];

`ifdef SHIFT_ARB_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (grant[PORT_ALU])    perf_grant0   <= perf_grant0 + 32'd1;
            if (grant[PORT_MULDIV]) perf_grant1   <= perf_grant1 + 32'd1;
            if (&elig)              perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule
